serial_add_scheduler: RTL



---
 rtl/serial_add_scheduler_pkg.sv | 18 +
 rtl/serial_add_scheduler_if.sv | 26 ++
 rtl/serial_add_core.sv | 51 +++++
 rtl/serial_add_scheduler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/serial_add_scheduler_pkg.sv
// Shared types and helpers for the round-robin serial-adder scheduler.
package serial_add_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions for width sizing.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_add_scheduler_if.sv
// Request/grant and result bus between client blocks and the serial-add scheduler.
interface serial_add_scheduler_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [WIDTH-1:0]      sum;
    logic                  cout;

    modport master (
        output req, a_in, b_in,
        input  gnt, busy, done, done_id, sum, cout
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, busy, done, done_id, sum, cout
    );
endinterface

// File: rtl/serial_add_core.sv
// Bit-serial LSB-first adder: operand/sum shift registers, carry flop and full adder.
module serial_add_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             clear_carry,
    input  logic [WIDTH-1:0] a_load,
    input  logic [WIDTH-1:0] b_load,
    output logic [WIDTH-1:0] sum_nxt_c,
    output logic             carry_nxt_c
);
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             bit_c;

    // Full adder on the current LSBs; the next sum word lets the caller capture the final result.
    always_comb begin
        bit_c       = a_q[0] ^ b_q[0] ^ carry_q;
        carry_nxt_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        sum_nxt_c   = {bit_c, sum_q[WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            if (load) begin
                a_q   <= a_load;
                b_q   <= b_load;
                sum_q <= '0;
            end else if (shift) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                sum_q <= sum_nxt_c;
            end
            if (clear_carry) begin
                carry_q <= 1'b0;
            end else if (shift) begin
                carry_q <= carry_nxt_c;
            end
        end
    end
endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin arbiter and sequencer sharing one bit-serial adder among NREQ clients.
module serial_add_scheduler
    import serial_add_scheduler_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    serial_add_scheduler_if.slave bus
);
    localparam int unsigned CNTW = clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   win_q, win_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             found_c;
    logic [IDW-1:0]   pick_c;
    int unsigned      idx;
    logic             load, shift, clear_carry;
    logic [WIDTH-1:0] a_sel_c, b_sel_c;
    logic [WIDTH-1:0] sum_nxt_c;
    logic             carry_nxt_c;

    // First asserted request at or after the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (32'(rr_q) + 32'(k)) % NREQ;
            if (!found_c && bus.req[idx]) begin
                found_c = 1'b1;
                pick_c  = IDW'(idx);
            end
        end
        a_sel_c = bus.a_in[32'(pick_c)*WIDTH +: WIDTH];
        b_sel_c = bus.b_in[32'(pick_c)*WIDTH +: WIDTH];
    end

    serial_add_core #(.WIDTH(WIDTH)) u_core (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .shift       (shift),
        .clear_carry (clear_carry),
        .a_load      (a_sel_c),
        .b_load      (b_sel_c),
        .sum_nxt_c   (sum_nxt_c),
        .carry_nxt_c (carry_nxt_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rr_q      <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        win_d       = win_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        load        = 1'b0;
        shift       = 1'b0;
        clear_carry = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    load        = 1'b1;
                    clear_carry = 1'b1;
                    win_d       = pick_c;
                    gnt_d       = NREQ'(1) << pick_c;
                    cnt_d       = CNTW'(WIDTH);
                    rr_d        = (pick_c == IDW'(NREQ - 1)) ? '0 : pick_c + 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                shift = 1'b1;
                cnt_d = cnt_q - 1'b1;
                // Last bit: capture the completed word as it leaves the adder.
                if (cnt_q == CNTW'(1)) begin
                    state_d   = ST_DONE;
                    gnt_d     = '0;
                    done_d    = 1'b1;
                    done_id_d = win_q;
                    sum_d     = sum_nxt_c;
                    cout_d    = carry_nxt_c;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
endmodule
